// File: rtl/cvxif_cplx_arbiter_pkg.sv
// rtl/cvxif_cplx_arbiter_pkg.sv - shared types and constants for the complex-ALU arbiter
package cvxif_cplx_pkg;

    localparam int CPLX_DATA_W  = 32;
    localparam int CPLX_MAX_REQ = 8;
    localparam int CPLX_ID_W    = 3;

    localparam logic [6:0] CPLX_OPCODE = 7'b1111011;
    localparam logic [2:0] FUNC3_ADD   = 3'b000;
    localparam logic [2:0] FUNC3_CONJ  = 3'b001;

    typedef enum logic {
        CPLX_ADD  = 1'b0,
        CPLX_CONJ = 1'b1
    } cplx_op_e;

    // One in-flight op: what to compute and which requester gets the result.
    typedef struct packed {
        cplx_op_e               op;
        logic [CPLX_DATA_W-1:0] a;
        logic [CPLX_DATA_W-1:0] b;
        logic [CPLX_ID_W-1:0]   id;
    } stage_t;

endpackage

// File: rtl/cvxif_cplx_arbiter_if.sv
// rtl/cvxif_cplx_arbiter_if.sv - per-requester request/response bundle for the complex-ALU arbiter
interface cvxif_cplx_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_op;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [NUM_REQ-1:0]        resp_ready;
    logic [NUM_REQ*DATA_W-1:0] resp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/cvxif_cplx_alu.sv
// rtl/cvxif_cplx_alu.sv - combinational complex add / conjugate on two packed lanes
module cvxif_cplx_alu
    import cvxif_cplx_pkg::*;
#(
    parameter int DATA_W = CPLX_DATA_W
) (
    input  cplx_op_e          op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c
);
    localparam int H = DATA_W / 2;

    logic [H-1:0] re;
    logic [H-1:0] im;

    // Lane-wise op; each lane wraps on its own, no carry crosses from im into re.
    always_comb begin
        re = a[DATA_W-1:H];
        im = a[H-1:0];
        case (op)
            CPLX_ADD: begin
                re = a[DATA_W-1:H] + b[DATA_W-1:H];
                im = a[H-1:0] + b[H-1:0];
            end
            CPLX_CONJ: begin
                re = a[DATA_W-1:H];
                im = -a[H-1:0];
            end
            default: ;
        endcase
    end

    assign c = {re, im};

endmodule

// File: rtl/cvxif_cplx_arbiter.sv
// rtl/cvxif_cplx_arbiter.sv - round-robin share of one complex ALU; CPLX_ARB_STATS_EN adds grant counters
module cvxif_cplx_arbiter
    import cvxif_cplx_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = CPLX_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    cvxif_cplx_arbiter_if.slave   bus
`ifdef CPLX_ARB_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [NUM_REQ*16-1:0] stat_grants
`endif
);

    logic [CPLX_ID_W-1:0] ptr_q;
    logic [CPLX_ID_W-1:0] grant_idx;
    logic                 grant_any;
    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   grant;

    stage_t               stg_d;
    stage_t               stg_q;
    logic                 stg_valid_q;
    logic [DATA_W-1:0]    alu_c;

    logic [NUM_REQ-1:0]   resp_valid_q;
    logic [DATA_W-1:0]    resp_data_q [NUM_REQ];

    // A lane may only request while it has nothing staged and nothing waiting in its buffer.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.req_valid[i] & ~resp_valid_q[i]
                        & ~(stg_valid_q & (stg_q.id == CPLX_ID_W'(i)));
        end
    end

    // Round-robin scan starting at ptr; first eligible lane wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_any && eligible[i] && (i == (int'(ptr_q) + k) % NUM_REQ)) begin
                    grant_any = 1'b1;
                    grant_idx = CPLX_ID_W'(i);
                    grant[i]  = 1'b1;
                end
            end
        end
    end

    assign bus.req_ready = grant;

    // Pointer moves just past the winner so it becomes lowest priority next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (grant_any) begin
            ptr_q <= (grant_idx == CPLX_ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Gather the winning lane's operands into the stage payload.
    always_comb begin
        stg_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                stg_d.op = cplx_op_e'(bus.req_op[i]);
                stg_d.a  = bus.req_a[i*DATA_W +: DATA_W];
                stg_d.b  = bus.req_b[i*DATA_W +: DATA_W];
                stg_d.id = CPLX_ID_W'(i);
            end
        end
    end

    // Single operand stage; empties on any cycle without a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid_q <= 1'b0;
            stg_q       <= '0;
        end else begin
            stg_valid_q <= grant_any;
            if (grant_any) begin
                stg_q <= stg_d;
            end
        end
    end

    cvxif_cplx_alu #(.DATA_W(DATA_W)) u_alu (
        .op (stg_q.op),
        .a  (stg_q.a),
        .b  (stg_q.b),
        .c  (alu_c)
    );

    // Per-requester 1-deep result buffers; capture and pop never target the same lane together.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                resp_valid_q[i] <= 1'b0;
                resp_data_q[i]  <= '0;
            end else if (stg_valid_q && (stg_q.id == CPLX_ID_W'(i))) begin
                resp_valid_q[i] <= 1'b1;
                resp_data_q[i]  <= alu_c;
            end else if (bus.resp_ready[i]) begin
                resp_valid_q[i] <= 1'b0;
            end
        end
    end

    // Flatten buffers onto the response bus.
    always_comb begin
        bus.resp_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.resp_data[i*DATA_W +: DATA_W] = resp_data_q[i];
        end
    end

    assign bus.resp_valid = resp_valid_q;

`ifdef CPLX_ARB_STATS_EN
    logic [15:0] grant_cnt_q [NUM_REQ];

    // Accepted-op counters; clear beats increment, counts stick at all-ones.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst || stat_clr) begin
                grant_cnt_q[i] <= '0;
            end else if (grant[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
                grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
            end
        end
    end

    // Flatten counters onto the stats port.
    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_grants[i*16 +: 16] = grant_cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_cvxif_cplx_arbiter.sv
// tb/tb_cvxif_cplx_arbiter.sv - randomized model-checked bench for cvxif_cplx_arbiter; CPLX_ARB_STATS_EN adds counter checks
module tb_cvxif_cplx_arbiter;
    import cvxif_cplx_pkg::*;

    localparam int N = 3;
    localparam int W = 32;
    localparam int H = W / 2;

    logic clk = 1'b0;
    logic rst;
    bit   clr_drv;

    always #5 clk = ~clk;

    cvxif_cplx_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

`ifdef CPLX_ARB_STATS_EN
    logic          stat_clr;
    logic [N*16-1:0] stat_grants;
    assign stat_clr = clr_drv;
`endif

    cvxif_cplx_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef CPLX_ARB_STATS_EN
        ,
        .stat_clr    (stat_clr),
        .stat_grants (stat_grants)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    int           m_ptr;
    bit           m_rv [N];
    logic [W-1:0] m_rd [N];
    int           m_pend_id;
    logic [W-1:0] m_pend_res;
    int           m_cnt [N];

    function automatic logic [W-1:0] alu_ref(bit op, logic [W-1:0] a, logic [W-1:0] b);
        int are, aim, bre, bim, re, im;
        are = int'(a[W-1:H]);
        aim = int'(a[H-1:0]);
        bre = int'(b[W-1:H]);
        bim = int'(b[H-1:0]);
        if (op) begin
            re = are;
            im = ((1 << H) - aim) % (1 << H);
        end else begin
            re = (are + bre) % (1 << H);
            im = (aim + bim) % (1 << H);
        end
        return {re[H-1:0], im[H-1:0]};
    endfunction

    function automatic void model_reset();
        m_ptr     = 0;
        m_pend_id = -1;
        m_pend_res = '0;
        for (int i = 0; i < N; i++) begin
            m_rv[i]  = 1'b0;
            m_rd[i]  = '0;
            m_cnt[i] = 0;
        end
    endfunction

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        g = '0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (bus.req_valid[i] && !m_rv[i] && (m_pend_id != i)) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic logic [N-1:0] model_rv();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_rv[i];
        return v;
    endfunction

    task automatic step();
        logic [N-1:0] g;
        g = model_grant();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++)
                if (m_rv[i] && bus.resp_ready[i]) m_rv[i] = 1'b0;
            if (m_pend_id >= 0) begin
                m_rv[m_pend_id] = 1'b1;
                m_rd[m_pend_id] = m_pend_res;
            end
            m_pend_id = -1;
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    m_pend_id  = i;
                    m_pend_res = alu_ref(bus.req_op[i], bus.req_a[i*W +: W], bus.req_b[i*W +: W]);
                    m_ptr      = (i + 1) % N;
                end
                if (clr_drv) m_cnt[i] = 0;
                else if (g[i] && m_cnt[i] < 65535) m_cnt[i]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_req(int i, bit v, bit op, logic [W-1:0] a, logic [W-1:0] b);
        bus.req_valid[i]     = v;
        bus.req_op[i]        = op;
        bus.req_a[i*W +: W]  = a;
        bus.req_b[i*W +: W]  = b;
    endtask

    task automatic idle();
        bus.req_valid  = '0;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_total++;
        if (bus.req_ready !== '0) $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); else n_pass++;
        n_total++;
        if (bus.resp_valid !== '0) $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); else n_pass++;
        n_total++;
        if (bus.resp_data !== '0) $display("FAIL reset_resp_data: got %h want 0", bus.resp_data); else n_pass++;
    endtask

    task automatic test_single_add();
        set_req(0, 1'b1, 1'b0, 32'h0003_0004, 32'h0001_0002);
        #1;
        n_total++;
        if (bus.req_ready !== 3'b001) $display("FAIL add_grant: got %b want 001", bus.req_ready); else n_pass++;
        step();
        set_req(0, 1'b0, 1'b0, '0, '0);
        #1;
        n_total++;
        if (bus.resp_valid !== 3'b000) $display("FAIL add_early_valid: got %b want 000", bus.resp_valid); else n_pass++;
        step();
        #1;
        n_total++;
        if (bus.resp_valid !== 3'b001) $display("FAIL add_valid: got %b want 001", bus.resp_valid); else n_pass++;
        n_total++;
        if (bus.resp_data[31:0] !== 32'h0004_0006) $display("FAIL add_data: got %h want 00040006", bus.resp_data[31:0]); else n_pass++;
        step();
        #1;
        n_total++;
        if (bus.resp_valid !== 3'b001 || bus.resp_data[31:0] !== 32'h0004_0006)
            $display("FAIL add_hold: valid %b data %h want 001 00040006", bus.resp_valid, bus.resp_data[31:0]);
        else n_pass++;
        bus.resp_ready[0] = 1'b1;
        step();
        bus.resp_ready = '0;
        #1;
        n_total++;
        if (bus.resp_valid !== 3'b000) $display("FAIL add_pop: got %b want 000", bus.resp_valid); else n_pass++;
    endtask

    task automatic test_conj();
        logic [W-1:0] av [2];
        logic [W-1:0] ev [2];
        av[0] = 32'h0005_8000; ev[0] = 32'h0005_8000;
        av[1] = 32'h0005_0001; ev[1] = 32'h0005_FFFF;
        bus.resp_ready = '1;
        for (int t = 0; t < 2; t++) begin
            set_req(1, 1'b1, 1'b1, av[t], $urandom);
            #1;
            n_total++;
            if (bus.req_ready !== 3'b010) $display("FAIL conj_grant%0d: got %b want 010", t, bus.req_ready); else n_pass++;
            step();
            set_req(1, 1'b0, 1'b0, '0, '0);
            step();
            #1;
            n_total++;
            if (bus.resp_valid[1] !== 1'b1 || bus.resp_data[63:32] !== ev[t])
                $display("FAIL conj_data%0d: valid %b data %h want 1 %h", t, bus.resp_valid[1], bus.resp_data[63:32], ev[t]);
            else n_pass++;
            step();
            #1;
            n_total++;
            if (bus.resp_valid !== 3'b000) $display("FAIL conj_pop%0d: got %b want 000", t, bus.resp_valid); else n_pass++;
        end
        bus.resp_ready = '0;
    endtask

    task automatic test_fairness();
        int  q[$];
        bit  alt_ok;
        do_reset();
        bus.resp_ready = '1;
        for (int c = 0; c < 12; c++) begin
            set_req(0, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
            set_req(1, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
            #1;
            n_total++;
            if (bus.req_ready !== model_grant()) $display("FAIL fair_grant c%0d: got %b want %b", c, bus.req_ready, model_grant()); else n_pass++;
            for (int i = 0; i < N; i++) if (bus.req_ready[i]) q.push_back(i);
            step();
        end
        n_total++;
        if (q.size() != 8) $display("FAIL fair_count: got %0d want 8", q.size()); else n_pass++;
        alt_ok = 1'b1;
        foreach (q[j]) if (q[j] != j % 2) alt_ok = 1'b0;
        n_total++;
        if (!alt_ok) $display("FAIL fair_order: got %p want 0,1,0,1...", q); else n_pass++;
        idle();
        bus.resp_ready = '1;
        repeat (3) step();
    endtask

    task automatic test_backpressure();
        int g0, g1;
        g0 = 0;
        g1 = 0;
        do_reset();
        bus.resp_ready = 3'b110;
        for (int c = 0; c < 12; c++) begin
            set_req(0, 1'b1, 1'b0, $urandom, $urandom);
            set_req(1, 1'b1, 1'b0, $urandom, $urandom);
            #1;
            n_total++;
            if (bus.req_ready !== model_grant()) $display("FAIL bp_grant c%0d: got %b want %b", c, bus.req_ready, model_grant()); else n_pass++;
            if (bus.req_ready[0]) g0++;
            if (bus.req_ready[1]) g1++;
            step();
        end
        n_total++;
        if (g0 != 1) $display("FAIL bp_req0_grants: got %0d want 1", g0); else n_pass++;
        n_total++;
        if (g1 != 4) $display("FAIL bp_req1_grants: got %0d want 4", g1); else n_pass++;
        bus.resp_ready[0] = 1'b1;
        #1;
        n_total++;
        if (bus.resp_valid[0] !== 1'b1) $display("FAIL bp_held: got %b want 1", bus.resp_valid[0]); else n_pass++;
        step();
        #1;
        n_total++;
        if (bus.req_ready !== 3'b001) $display("FAIL bp_regrant: got %b want 001", bus.req_ready); else n_pass++;
        idle();
        bus.resp_ready = '1;
        repeat (3) step();
    endtask

    task automatic test_reset_midop();
        do_reset();
        bus.resp_ready = '1;
        set_req(0, 1'b1, 1'b0, $urandom, $urandom);
        #1;
        n_total++;
        if (bus.req_ready !== 3'b001) $display("FAIL rmid_grant: got %b want 001", bus.req_ready); else n_pass++;
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_total++;
            if (bus.resp_valid !== 3'b000) $display("FAIL rmid_no_resp c%0d: got %b want 000", c, bus.resp_valid); else n_pass++;
            step();
        end
        set_req(0, 1'b1, 1'b0, $urandom, $urandom);
        set_req(1, 1'b1, 1'b0, $urandom, $urandom);
        #1;
        n_total++;
        if (bus.req_ready !== 3'b001) $display("FAIL rmid_first_grant: got %b want 001", bus.req_ready); else n_pass++;
        idle();
        bus.resp_ready = '1;
        repeat (3) step();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                logic [W-1:0] a;
                a = $urandom;
                if ($urandom_range(0, 7) == 0) a[H-1:0] = 16'h8000;
                if ($urandom_range(0, 7) == 0) a[W-1:H] = 16'hFFFF;
                set_req(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, $urandom);
                bus.resp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            clr_drv = ($urandom_range(0, 31) == 0);
            rst     = ($urandom_range(0, 99) == 0);
            #1;
            n_total++;
            if (bus.req_ready !== model_grant()) $display("FAIL rnd_grant c%0d: got %b want %b", c, bus.req_ready, model_grant()); else n_pass++;
            n_total++;
            if (bus.resp_valid !== model_rv()) $display("FAIL rnd_valid c%0d: got %b want %b", c, bus.resp_valid, model_rv()); else n_pass++;
            for (int i = 0; i < N; i++) begin
                if (m_rv[i]) begin
                    n_total++;
                    if (bus.resp_data[i*W +: W] !== m_rd[i]) $display("FAIL rnd_data c%0d r%0d: got %h want %h", c, i, bus.resp_data[i*W +: W], m_rd[i]); else n_pass++;
                end
`ifdef CPLX_ARB_STATS_EN
                n_total++;
                if (stat_grants[i*16 +: 16] !== 16'(m_cnt[i])) $display("FAIL rnd_stat c%0d r%0d: got %0d want %0d", c, i, stat_grants[i*16 +: 16], m_cnt[i]); else n_pass++;
`endif
            end
            step();
        end
        rst     = 1'b0;
        clr_drv = 1'b0;
        idle();
    endtask

`ifdef CPLX_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        clr_drv = 1'b0;
        bus.resp_ready = '1;
        for (int c = 0; c < 9; c++) begin
            set_req(1, 1'b1, 1'b0, $urandom, $urandom);
            step();
        end
        #1;
        n_total++;
        if (stat_grants[31:16] !== 16'd3) $display("FAIL stat_three: got %0d want 3", stat_grants[31:16]); else n_pass++;
        n_total++;
        if (stat_grants[15:0] !== 16'd0) $display("FAIL stat_req0: got %0d want 0", stat_grants[15:0]); else n_pass++;
        n_total++;
        if (bus.req_ready !== 3'b010) $display("FAIL stat_clr_grant: got %b want 010", bus.req_ready); else n_pass++;
        clr_drv = 1'b1;
        step();
        clr_drv = 1'b0;
        idle();
        #1;
        n_total++;
        if (stat_grants[31:16] !== 16'd0) $display("FAIL stat_clr_prio: got %0d want 0", stat_grants[31:16]); else n_pass++;
        bus.resp_ready = '1;
        repeat (3) step();
    endtask
`endif

    initial begin
        rst     = 1'b1;
        clr_drv = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_add();
        test_conj();
        test_fairness();
        test_backpressure();
        test_reset_midop();
`ifdef CPLX_ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
